rr_arbiter_param: RTL and testbench

- Parametrised N-way round-robin arbiter. Next generation of the team's 4-way FSM arbiter.
- Adds configurable requester count, per-requester masking, and grant hold with a bounded burst length.
- Adds registered one-hot grant, index and valid outputs.
- Sits in front of a shared resource (bus/port) and picks one requester per cycle with starvation-free fairness.

---
 rtl/arb_pkg.sv | 18 +
 rtl/rr_pick.sv | 51 +++++
 rtl/rr_arbiter_param.sv | 146 ++++++++++++++
 tb/tb_rr_arbiter_param.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared constants and mode encoding for the round-robin arbiter
//
// Purpose: default parameter values and the arbiter mode enum.
// Contents:
//   ARB_N_DEF     default number of requesters
//   ARB_BURST_DEF default maximum burst length
//   arb_mode_e    ARB_IDLE (no owner) / ARB_OWNED (grant held by owner)
package arb_pkg;

  localparam int ARB_N_DEF     = 4;
  localparam int ARB_BURST_DEF = 1;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_OWNED = 1'b1
  } arb_mode_e;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotated priority encoder
//
// Purpose: return the first set bit of vector, searching from index start
//          upwards and wrapping modulo N (not modulo 2^IDX_W).
// Ports:
//   vector [N]     candidate bits
//   start  [IDX_W] first index searched, must be < N
//   idx    [IDX_W] index of the first set bit found; 0 when none
//   found  [1]     high when vector has any bit set
module rr_pick
  import arb_pkg::*;
#(
  parameter int N     = ARB_N_DEF,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     vector,
  input  logic [IDX_W-1:0] start,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  // (a + k) mod N; a < N and k < N, so one conditional subtract suffices.
  function automatic logic [IDX_W-1:0] mod_add(input logic [IDX_W-1:0] a, input int k);
    logic [IDX_W:0] s;
    s = {1'b0, a} + (IDX_W+1)'(k);
    if (s >= (IDX_W+1)'(N)) begin
      s = s - (IDX_W+1)'(N);
    end
    return IDX_W'(s);
  endfunction

  logic [N-1:0] rot;

  always_comb begin
    rot   = '0;
    idx   = '0;
    found = 1'b0;
    // Rotate so that bit 0 of rot corresponds to index start.
    for (int k = 0; k < N; k++) begin
      rot[k] = vector[mod_add(start, k)];
    end
    found = |rot;
    // Descending scan so the lowest rotated position wins.
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        idx = mod_add(start, k);
      end
    end
  end

endmodule

// File: rtl/rr_arbiter_param.sv
// rtl/rr_arbiter_param.sv - parametrised N-way round-robin arbiter with burst hold
//
// Purpose: grants one requester per cycle with round-robin fairness; an owner
//          may keep the grant for up to MAX_BURST cycles while others wait,
//          and indefinitely when uncontended.
// Ports:
//   clk         [1]     clock, rising edge
//   rst         [1]     synchronous active-low reset
//   req         [N]     request vector
//   req_mask    [N]     bit i = 1 blocks requester i
//   grant       [N]     registered one-hot grant, zero when idle
//   grant_idx   [IDX_W] registered owner index, zero when idle
//   grant_valid [1]     registered, high when grant is non-zero
module rr_arbiter_param
  import arb_pkg::*;
#(
  parameter int N         = ARB_N_DEF,
  parameter int MAX_BURST = ARB_BURST_DEF,
  parameter int IDX_W     = $clog2(N),
  parameter int CNT_W     = $clog2(MAX_BURST + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     req_mask,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid
);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] x);
    return (x == IDX_LAST) ? '0 : x + 1'b1;
  endfunction

  function automatic logic [N-1:0] to_onehot(input logic [IDX_W-1:0] i);
    logic [N-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  arb_mode_e        mode_q, mode_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
  logic             grant_valid_q, grant_valid_d;

  logic [N-1:0]     eligible;
  logic [IDX_W-1:0] pick_start;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;
  logic             owner_elig;
  logic             others_elig;

  assign eligible    = req & ~req_mask;
  assign owner_elig  = eligible[owner_q];
  assign others_elig = |(eligible & ~to_onehot(owner_q));

  // From idle the search resumes after the most recent owner; while owned it
  // starts after the current owner. One encoder serves both cases.
  assign pick_start = (mode_q == ARB_IDLE) ? wrap_inc(last_q) : wrap_inc(owner_q);

  rr_pick #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_pick (
    .vector (eligible),
    .start  (pick_start),
    .idx    (pick_idx),
    .found  (pick_found)
  );

  always_comb begin
    mode_d  = mode_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (mode_q)
      ARB_IDLE: begin
        if (pick_found) begin
          mode_d  = ARB_OWNED;
          owner_d = pick_idx;
          last_d  = pick_idx;
          cnt_d   = CNT_ONE;
        end
      end
      ARB_OWNED: begin
        if (owner_elig && ((cnt_q < CNT_MAX) || !others_elig)) begin
          // Keep the owner; the counter saturates so an uncontended owner
          // holds forever and yields as soon as a competitor appears.
          if (cnt_q < CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (pick_found) begin
          owner_d = pick_idx;
          last_d  = pick_idx;
          cnt_d   = CNT_ONE;
        end else begin
          mode_d = ARB_IDLE;
        end
      end
      default: mode_d = ARB_IDLE;
    endcase

    // Outputs are registered copies of the next state.
    grant_d       = '0;
    grant_idx_d   = '0;
    grant_valid_d = 1'b0;
    if (mode_d == ARB_OWNED) begin
      grant_d       = to_onehot(owner_d);
      grant_idx_d   = owner_d;
      grant_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mode_q        <= ARB_IDLE;
      owner_q       <= '0;
      last_q        <= IDX_LAST;
      cnt_q         <= '0;
      grant_q       <= '0;
      grant_idx_q   <= '0;
      grant_valid_q <= 1'b0;
    end else begin
      mode_q        <= mode_d;
      owner_q       <= owner_d;
      last_q        <= last_d;
      cnt_q         <= cnt_d;
      grant_q       <= grant_d;
      grant_idx_q   <= grant_idx_d;
      grant_valid_q <= grant_valid_d;
    end
  end

  assign grant       = grant_q;
  assign grant_idx   = grant_idx_q;
  assign grant_valid = grant_valid_q;

endmodule

// File: tb/tb_rr_arbiter_param.sv
// tb/tb_rr_arbiter_param.sv - scoreboard bench for rr_arbiter_param
module tb_rr_arbiter_param;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // a: N=4 MAX_BURST=3, b: N=4 MAX_BURST=1, c: N=5 MAX_BURST=1
  logic       rst_a, rst_b, rst_c;
  logic [3:0] req_a, mask_a, grant_a;
  logic [1:0] idx_a;
  logic       valid_a;
  logic [3:0] req_b, mask_b, grant_b;
  logic [1:0] idx_b;
  logic       valid_b;
  logic [4:0] req_c, mask_c, grant_c;
  logic [2:0] idx_c;
  logic       valid_c;

  rr_arbiter_param #(.N(4), .MAX_BURST(3)) dut_a (
    .clk(clk), .rst(rst_a), .req(req_a), .req_mask(mask_a),
    .grant(grant_a), .grant_idx(idx_a), .grant_valid(valid_a));
  rr_arbiter_param #(.N(4), .MAX_BURST(1)) dut_b (
    .clk(clk), .rst(rst_b), .req(req_b), .req_mask(mask_b),
    .grant(grant_b), .grant_idx(idx_b), .grant_valid(valid_b));
  rr_arbiter_param #(.N(5), .MAX_BURST(1)) dut_c (
    .clk(clk), .rst(rst_c), .req(req_c), .req_mask(mask_c),
    .grant(grant_c), .grant_idx(idx_c), .grant_valid(valid_c));

  int checks_total  = 0;
  int checks_passed = 0;

  task automatic check(input string nm, input int act, input int exp);
    checks_total++;
    if (act == exp) checks_passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // Reference model: plain integers, one slot per DUT.
  typedef struct {int grant; int idx;} exp_t;
  exp_t exp_q[3][$];
  int   m_n[3]  = '{4, 4, 5};
  int   m_mb[3] = '{3, 1, 1};
  bit   m_owned[3];
  int   m_owner[3], m_last[3], m_cnt[3];

  function automatic int ref_pick(input int elig, input int start, input int n);
    for (int k = 0; k < n; k++) begin
      int c;
      c = (start + k) % n;
      if (((elig >> c) & 1) != 0) return c;
    end
    return -1;
  endfunction

  function automatic void model_step(input int d, input int req, input int mask, input bit rstn);
    int n, elig, others, o;
    exp_t e;
    n = m_n[d];
    if (!rstn) begin
      m_owned[d] = 0; m_owner[d] = 0; m_last[d] = n - 1; m_cnt[d] = 0;
    end else begin
      elig = req & ~mask & ((1 << n) - 1);
      if (!m_owned[d]) begin
        if (elig != 0) begin
          o = ref_pick(elig, (m_last[d] + 1) % n, n);
          m_owned[d] = 1; m_owner[d] = o; m_last[d] = o; m_cnt[d] = 1;
        end
      end else begin
        others = elig & ~(1 << m_owner[d]);
        if (((elig >> m_owner[d]) & 1) != 0 && (m_cnt[d] < m_mb[d] || others == 0)) begin
          if (m_cnt[d] < m_mb[d]) m_cnt[d]++;
        end else if (elig != 0) begin
          o = ref_pick(elig, (m_owner[d] + 1) % n, n);
          m_owner[d] = o; m_last[d] = o; m_cnt[d] = 1;
        end else begin
          m_owned[d] = 0;
        end
      end
    end
    e.grant = m_owned[d] ? (1 << m_owner[d]) : 0;
    e.idx   = m_owned[d] ? m_owner[d] : 0;
    exp_q[d].push_back(e);
  endfunction

  // Monitor: one expectation per DUT per edge, compared just after the edge.
  task automatic mon_cmp(input string tag, input exp_t e, input int g, input int i, input int v);
    check({tag, "_grant"}, g, e.grant);
    check({tag, "_idx"}, i, e.idx);
    check({tag, "_valid"}, v, (e.grant != 0) ? 1 : 0);
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q[0].size() > 0) mon_cmp("sb_a", exp_q[0].pop_front(), int'(grant_a), int'(idx_a), int'(valid_a));
    if (exp_q[1].size() > 0) mon_cmp("sb_b", exp_q[1].pop_front(), int'(grant_b), int'(idx_b), int'(valid_b));
    if (exp_q[2].size() > 0) mon_cmp("sb_c", exp_q[2].pop_front(), int'(grant_c), int'(idx_c), int'(valid_c));
  end

  // Inputs are set at a negedge; tick() records the expectation for the coming
  // edge and returns at the following negedge.
  task automatic tick();
    model_step(0, int'(req_a), int'(mask_a), rst_a);
    model_step(1, int'(req_b), int'(mask_b), rst_b);
    model_step(2, int'(req_c), int'(mask_c), rst_c);
    @(negedge clk);
  endtask

  initial begin
    rst_a = 0; rst_b = 0; rst_c = 0;
    req_a = '0; req_b = '0; req_c = '0;
    mask_a = '0; mask_b = '0; mask_c = '0;
    @(negedge clk);

    // Reset held with requests pending, then full rotation at MAX_BURST=3.
    req_a = 4'b1111;
    tick(); check("rst_grant0", int'(grant_a), 0);
    tick(); check("rst_grant1", int'(grant_a), 0); check("rst_valid", int'(valid_a), 0);
    rst_a = 1;
    for (int i = 0; i < 15; i++) begin
      tick();
      check("rotation", int'(grant_a), 1 << ((i / 3) % 4));
    end
    check("rotation_idx", int'(idx_a), 0);

    // Uncontended hold then release.
    rst_a = 0; tick(); rst_a = 1;
    req_a = 4'b0100;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold", int'(grant_a), 4'b0100);
    end
    req_a = 4'b0000; tick(); check("hold_release", int'(grant_a), 0);

    // Early release hands over without a bubble; reset drops grant mid-burst.
    rst_a = 0; tick(); rst_a = 1;
    req_a = 4'b0101;
    tick(); check("early_0", int'(grant_a), 4'b0001);
    tick(); check("early_1", int'(grant_a), 4'b0001);
    req_a = 4'b0100;
    tick(); check("early_switch", int'(grant_a), 4'b0100);
    tick(); check("early_keep", int'(grant_a), 4'b0100);
    rst_a = 0;
    tick(); check("midburst_rst", int'(grant_a), 0); check("midburst_valid", int'(valid_a), 0);
    rst_a = 1; req_a = 4'b0000;

    // Mask skips requester 1; clearing it restores it after owner 0.
    rst_b = 1; req_b = 4'b1111; mask_b = 4'b0010;
    tick(); check("mask_0", int'(grant_b), 4'b0001);
    tick(); check("mask_1", int'(grant_b), 4'b0100);
    tick(); check("mask_2", int'(grant_b), 4'b1000);
    tick(); check("mask_3", int'(grant_b), 4'b0001);
    mask_b = 4'b0000;
    tick(); check("unmask_0", int'(grant_b), 4'b0010);
    tick(); check("unmask_1", int'(grant_b), 4'b0100);
    req_b = 4'b0000;

    // N=5 wrap from owner 4 and search from last+1 when idle.
    rst_c = 1; req_c = 5'b10000;
    tick(); check("n5_own4", int'(grant_c), 5'b10000); check("n5_idx4", int'(idx_c), 4);
    req_c = 5'b00011;
    tick(); check("n5_wrap", int'(grant_c), 5'b00001);
    tick(); check("n5_next", int'(grant_c), 5'b00010);
    req_c = 5'b00000;
    tick(); check("n5_idle", int'(grant_c), 0);
    req_c = 5'b01001;
    tick(); check("n5_from_last", int'(grant_c), 5'b01000); check("n5_idx3", int'(idx_c), 3);

    // Randomised traffic, checked only through the scoreboard.
    for (int i = 0; i < 400; i++) begin
      rst_a = ($urandom_range(0, 31) != 0);
      rst_b = ($urandom_range(0, 31) != 0);
      rst_c = ($urandom_range(0, 31) != 0);
      req_a = 4'($urandom()); mask_a = 4'($urandom() & $urandom() & $urandom());
      req_b = 4'($urandom()); mask_b = 4'($urandom() & $urandom() & $urandom());
      req_c = 5'($urandom()); mask_c = 5'($urandom() & $urandom() & $urandom());
      if (i % 50 < 20) begin
        req_a = 4'b1111; req_b = 4'b1111; req_c = 5'b11111;
      end
      tick();
    end

    @(negedge clk);
    check("queue_drained", exp_q[0].size() + exp_q[1].size() + exp_q[2].size(), 0);
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
